// File: rtl/mem_pkg.sv
// Shared types and sizing for the timed main-memory responder.
// The line geometry and countdown width are fixed here so the FSM and storage agree.
package mem_pkg;

    localparam int unsigned ADDR_W          = 10;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned LINE_W          = DATA_W * WORDS_PER_BLOCK;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrWait,
        StDone
    } mem_state_e;

endpackage

// File: rtl/mem_storage_array.sv
// Backing store: synchronous single-word write port plus a full-line read port.
// Line word 0 sits in the least significant DATA_W bits.
module mem_storage_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W          = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W          = mem_pkg::DATA_W,
    parameter int unsigned WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
    parameter string       INIT_FILE       = "",
    localparam int unsigned OffW           = $clog2(WORDS_PER_BLOCK),
    localparam int unsigned LineW          = DATA_W * WORDS_PER_BLOCK
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [ADDR_W-OffW-1:0] rblock,
    output logic [LineW-1:0]       rline
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rline = '0;
        for (int w = 0; w < int'(WORDS_PER_BLOCK); w++) begin
            rline[w*DATA_W +: DATA_W] = mem[{rblock, w[OffW-1:0]}];
        end
    end

endmodule

// File: rtl/timed_memory_responder.sv
// Main-memory responder: accepts refill/write-through requests, waits a fixed
// latency, then completes each with a one-cycle ready pulse.
module timed_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W          = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W          = mem_pkg::DATA_W,
    parameter int unsigned WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
    parameter int unsigned READ_LATENCY    = 4,
    parameter int unsigned WRITE_LATENCY   = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              read_en_memory,
    input  logic                              write_en_memory,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [DATA_W-1:0]                 DataIn,
    output logic                              ready_signal_memory,
    output logic [DATA_W*WORDS_PER_BLOCK-1:0] DataOut,
    output logic                              busy
);

    localparam int unsigned OffW   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned LineW  = DATA_W * WORDS_PER_BLOCK;
    localparam int unsigned MaxLat = 2**CNT_W - 1;
    localparam logic [CNT_W-1:0] RdLoad = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WrLoad = CNT_W'(WRITE_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > MaxLat ||
        WRITE_LATENCY < 1 || WRITE_LATENCY > MaxLat) begin : g_bad_latency
        $error("timed_memory_responder: latency parameters must lie in 1..%0d", MaxLat);
    end

    mem_state_e        state;
    logic [CNT_W-1:0]  counter;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              mem_we;
    logic [LineW-1:0]  rd_line;

    // Commit only on the final countdown cycle so a reset in WR_WAIT drops the write.
    assign mem_we = (state == StWrWait) && (counter == '0);

    mem_storage_array #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_storage (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (addr_q),
        .wdata  (data_q),
        .rblock (addr_q[ADDR_W-1:OffW]),
        .rline  (rd_line)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= StIdle;
            counter             <= '0;
            addr_q              <= '0;
            data_q              <= '0;
            ready_signal_memory <= 1'b0;
            DataOut             <= '0;
            busy                <= 1'b0;
        end else begin
            ready_signal_memory <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Write wins a tie; the read stays pending on its level request.
                    if (write_en_memory) begin
                        addr_q  <= address;
                        data_q  <= DataIn;
                        counter <= WrLoad;
                        busy    <= 1'b1;
                        state   <= StWrWait;
                    end else if (read_en_memory) begin
                        addr_q  <= {address[ADDR_W-1:OffW], OffW'(0)};
                        counter <= RdLoad;
                        busy    <= 1'b1;
                        state   <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (counter == '0) begin
                        DataOut             <= rd_line;
                        ready_signal_memory <= 1'b1;
                        state               <= StDone;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                StWrWait: begin
                    if (counter == '0) begin
                        ready_signal_memory <= 1'b1;
                        state               <= StDone;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timed_memory_responder.sv
// Self-checking bench for timed_memory_responder: directed table, corner sequences
// and randomized traffic against a word-array reference model.
module tb_timed_memory_responder;

    localparam int RL = 4;
    localparam int WL = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         read_en_memory = 1'b0;
    logic         write_en_memory = 1'b0;
    logic [9:0]   address = '0;
    logic [31:0]  DataIn = '0;
    logic         ready_signal_memory;
    logic [127:0] DataOut;
    logic         busy;

    int checks = 0;
    int failures = 0;

    logic [31:0]  model_mem [1024];
    logic [127:0] model_dout = '0;

    always #5 clk = ~clk;

    timed_memory_responder #(
        .ADDR_W          (10),
        .DATA_W          (32),
        .WORDS_PER_BLOCK (4),
        .READ_LATENCY    (RL),
        .WRITE_LATENCY   (WL)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .read_en_memory      (read_en_memory),
        .write_en_memory     (write_en_memory),
        .address             (address),
        .DataIn              (DataIn),
        .ready_signal_memory (ready_signal_memory),
        .DataOut             (DataOut),
        .busy                (busy)
    );

    typedef struct {
        bit           is_wr;
        logic [9:0]   addr;
        logic [31:0]  data;
        bit           chk_line;
        logic [127:0] exp_line;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    endfunction

    // Line = the four words of the aligned block holding a, lowest address in the low bits.
    function automatic logic [127:0] model_line(input logic [9:0] a);
        int base;
        logic [127:0] l;
        base = int'(a) - (int'(a) % 4);
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = model_mem[base + w];
        return l;
    endfunction

    // Cycle k is the k-th cycle after the accepting edge; returns -1 on timeout.
    task automatic wait_ready(input string name, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready_signal_memory === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: ready timeout, got none within 40 cycles, required one", name);
        end
    endtask

    // Called with the DUT idle, #1 after a rising edge; returns likewise.
    task automatic transact(input bit is_wr, input logic [9:0] a, input logic [31:0] d,
                            input bit scramble, input string name);
        int lat;
        address         = a;
        DataIn          = d;
        write_en_memory = is_wr;
        read_en_memory  = !is_wr;
        @(posedge clk); #1;
        if (scramble) begin
            address = 10'($urandom);
            DataIn  = $urandom;
        end
        wait_ready(name, lat);
        write_en_memory = 1'b0;
        read_en_memory  = 1'b0;
        if (lat >= 0) begin
            check({name, " latency"}, 128'(lat), 128'(is_wr ? WL + 1 : RL + 1));
            if (is_wr) model_mem[a] = d;
            else model_dout = model_line(a);
        end
        check({name, " DataOut"}, DataOut, model_dout);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;

        vecs[0] = '{1'b1, 10'h020, 32'h1111_1111, 1'b0, '0};
        vecs[1] = '{1'b1, 10'h021, 32'h2222_2222, 1'b0, '0};
        vecs[2] = '{1'b1, 10'h022, 32'h3333_3333, 1'b0, '0};
        vecs[3] = '{1'b1, 10'h023, 32'h4444_4444, 1'b0, '0};
        vecs[4] = '{1'b0, 10'h022, 32'h0, 1'b1, 128'h44444444_33333333_22222222_11111111};
        vecs[5] = '{1'b1, 10'h3FC, 32'hC0DE_0000, 1'b0, '0};
        vecs[6] = '{1'b1, 10'h3FD, 32'hC0DE_0001, 1'b0, '0};
        vecs[7] = '{1'b1, 10'h3FE, 32'hC0DE_0002, 1'b0, '0};
        vecs[8] = '{1'b1, 10'h3FF, 32'hC0DE_0003, 1'b0, '0};
        vecs[9] = '{1'b0, 10'h3FF, 32'h0, 1'b1, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000};

        // Reset state
        #3 rst = 1'b0;
        #10;
        check("reset ready", 128'(ready_signal_memory), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset DataOut", DataOut, '0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Fill the whole store through the write port so every word is known.
        for (int i = 0; i < 1024; i++) transact(1'b1, 10'(i), init_val(i), 1'b0, "init");

        // Directed table: write-then-refill and the top block.
        for (int i = 0; i < 10; i++) begin
            transact(vecs[i].is_wr, vecs[i].addr, vecs[i].data, 1'b0, $sformatf("vec%0d", i));
            if (vecs[i].chk_line) check($sformatf("vec%0d line", i), DataOut, vecs[i].exp_line);
        end

        // Reset while a write is counting down: the write must not land.
        address = 10'h010; DataIn = 32'hDEAD_BEEF; write_en_memory = 1'b1;
        @(posedge clk); #1;
        write_en_memory = 1'b0;
        @(negedge clk);
        check("midwrite busy", 128'(busy), 128'(1));
        rst = 1'b0;
        #1;
        check("midwrite rst ready", 128'(ready_signal_memory), 128'(0));
        check("midwrite rst busy", 128'(busy), 128'(0));
        check("midwrite rst DataOut", DataOut, '0);
        model_dout = '0;
        repeat (2) @(negedge clk);
        check("midwrite rst hold busy", 128'(busy), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        transact(1'b0, 10'h010, 32'h0, 1'b0, "abort read");
        check("abort word0", 128'(DataOut[31:0]), 128'(init_val(16)));

        // Simultaneous read and write: write first, read after one idle cycle.
        address = 10'h040; DataIn = 32'hA5A5_A5A5;
        read_en_memory = 1'b1; write_en_memory = 1'b1;
        @(posedge clk); #1;
        wait_ready("simul write", lat);
        write_en_memory = 1'b0;
        check("simul write latency", 128'(lat), 128'(WL + 1));
        check("simul done busy", 128'(busy), 128'(1));
        model_mem[10'h040] = 32'hA5A5_A5A5;
        @(negedge clk);
        check("simul idle busy", 128'(busy), 128'(0));
        check("simul idle ready", 128'(ready_signal_memory), 128'(0));
        wait_ready("simul read", lat);
        read_en_memory = 1'b0;
        check("simul read latency", 128'(lat), 128'(RL + 1));
        check("simul word0", 128'(DataOut[31:0]), 128'(32'hA5A5_A5A5));
        model_dout = model_line(10'h040);
        check("simul line", DataOut, model_dout);
        @(posedge clk); #1;

        // Address moves after acceptance: refill must still come from block 0x080.
        address = 10'h080; read_en_memory = 1'b1;
        @(posedge clk); #1;
        address = 10'h100;
        wait_ready("stable read", lat);
        read_en_memory = 1'b0;
        check("stable latency", 128'(lat), 128'(RL + 1));
        model_dout = model_line(10'h080);
        check("stable line", DataOut, model_dout);
        @(posedge clk); #1;

        // Back-to-back reads with the request held: period is RL+1 busy cycles plus one idle.
        address = 10'h0C4; read_en_memory = 1'b1;
        @(posedge clk); #1;
        model_dout = model_line(10'h0C4);
        for (int k = 1; k <= 2 * (RL + 2); k++) begin
            @(negedge clk);
            check($sformatf("b2b busy c%0d", k), 128'(busy),
                  128'(((k - 1) % (RL + 2)) != RL + 1));
            check($sformatf("b2b ready c%0d", k), 128'(ready_signal_memory),
                  128'(((k - 1) % (RL + 2)) == RL));
            if (k == 2 * (RL + 2) - 1) read_en_memory = 1'b0;
        end
        check("b2b line", DataOut, model_dout);
        @(posedge clk); #1;
        transact(1'b1, 10'h200, 32'h0BAD_F00D, 1'b0, "b2b other-block write");
        transact(1'b1, 10'h0C5, 32'h1234_5678, 1'b0, "b2b same-block write");
        transact(1'b0, 10'h0C7, 32'h0, 1'b0, "b2b reread");
        check("b2b reread word1", 128'(DataOut[63:32]), 128'(32'h1234_5678));

        // Randomized traffic, operands disturbed after acceptance.
        for (int i = 0; i < 300; i++) begin
            transact(1'($urandom_range(0, 1)), 10'($urandom), $urandom,
                     1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
